// File: rtl/fifo_ring.sv
// fifo_ring: single-clock ring-buffer FIFO with fill count, almost-full/empty flags and sticky error status.
// Latency: a write is visible on `out` the cycle after the edge (first-word-fall-through), no empty bypass.
// Backpressure: none; a write when full either drops the oldest entry (OVERWRITE=1) or is refused (OVERWRITE=0).
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   write_trig, in    push `in` this cycle
//   read_trig, out    pop the head; `out` shows the head combinationally
//   count             entries stored, 0..DEPTH
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   overflow          sticky: a write lost or refused data
//   underflow         sticky: a read while empty
//   clear_status      clears overflow/underflow (a same-cycle set wins)

module fifo_ring #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter bit OVERWRITE = 1'b1,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_trig,
    input  logic              read_trig,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2) begin : g_err_depth_small
            $error("fifo_ring: DEPTH must be >= 2");
        end
        if ((DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth_pow2
            $error("fifo_ring: DEPTH must be a power of two");
        end
        if (AF_LEVEL > DEPTH) begin : g_err_af
            $error("fifo_ring: AF_LEVEL must not exceed DEPTH");
        end
        if (AE_LEVEL > DEPTH) begin : g_err_ae
            $error("fifo_ring: AE_LEVEL must not exceed DEPTH");
        end
    endgenerate

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // while every one of the DEPTH slots holds data.
    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic          do_write;
    logic          do_read;
    logic          drop_oldest;
    logic [PW-1:0] fill;

    assign fill  = wp_q - rp_q;
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

    always_comb begin
        do_read     = read_trig && !empty;
        // A simultaneous read frees a slot, so a write when full is only
        // refused or destructive when no read accompanies it.
        do_write    = write_trig && (!full || read_trig || OVERWRITE);
        drop_oldest = write_trig && full && !read_trig && OVERWRITE;

        wp_d = wp_q + PW'(do_write);
        rp_d = rp_q + PW'(do_read || drop_oldest);

        // Set events beat a same-cycle clear.
        ovf_d = (ovf_q && !clear_status) || (write_trig && full && !read_trig);
        udf_d = (udf_q && !clear_status) || (read_trig && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage has no reset so it maps onto a single-write-port, async-read RAM.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_q[wp_q[AW-1:0]] <= in;
        end
    end

    assign out          = mem_q[rp_q[AW-1:0]];
    assign count        = CW'(fill);
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ring.sv
module tb_fifo_ring;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              write_trig;
    logic              read_trig;
    logic              clear_status;
    logic [DATA_W-1:0] din;

    // Index 0: overwrite-oldest instance, index 1: reject-new instance.
    logic [DATA_W-1:0] out_o [2];
    logic [CW-1:0]     cnt_o [2];
    logic              full_o [2];
    logic              empty_o [2];
    logic              af_o [2];
    logic              ae_o [2];
    logic              ovf_o [2];
    logic              udf_o [2];

    fifo_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut_ow (
        .clk(clk), .reset(reset), .write_trig(write_trig), .read_trig(read_trig),
        .in(din), .out(out_o[0]), .count(cnt_o[0]), .full(full_o[0]), .empty(empty_o[0]),
        .almost_full(af_o[0]), .almost_empty(ae_o[0]), .overflow(ovf_o[0]),
        .underflow(udf_o[0]), .clear_status(clear_status)
    );

    fifo_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut_rj (
        .clk(clk), .reset(reset), .write_trig(write_trig), .read_trig(read_trig),
        .in(din), .out(out_o[1]), .count(cnt_o[1]), .full(full_o[1]), .empty(empty_o[1]),
        .almost_full(af_o[1]), .almost_empty(ae_o[1]), .overflow(ovf_o[1]),
        .underflow(udf_o[1]), .clear_status(clear_status)
    );

    // Reference model: an ordered list per instance, oldest entry at index 0.
    logic [DATA_W-1:0] mlist [2][DEPTH];
    int                msz [2];
    bit                movf [2];
    bit                mudf [2];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic m_pop(input int k);
        for (int i = 0; i < DEPTH - 1; i++) mlist[k][i] = mlist[k][i+1];
        msz[k]--;
    endtask

    task automatic m_push(input int k, input logic [DATA_W-1:0] d);
        mlist[k][msz[k]] = d;
        msz[k]++;
    endtask

    task automatic m_step(input int k, input bit ow, input bit rst, input bit w, input bit r,
                          input logic [DATA_W-1:0] d, input bit clr);
        bit was_empty, was_full;
        if (rst) begin
            msz[k]  = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
            return;
        end
        was_empty = (msz[k] == 0);
        was_full  = (msz[k] == DEPTH);
        movf[k] = (movf[k] && !clr) || (w && was_full && !r);
        mudf[k] = (mudf[k] && !clr) || (r && was_empty);
        if (r && !was_empty) m_pop(k);
        if (w) begin
            if (!was_full || r) m_push(k, d);
            else if (ow) begin
                m_pop(k);
                m_push(k, d);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("count", k, 32'(cnt_o[k]), 32'(msz[k]));
            chk("empty", k, 32'(empty_o[k]), 32'(msz[k] == 0));
            chk("full", k, 32'(full_o[k]), 32'(msz[k] == DEPTH));
            chk("almost_full", k, 32'(af_o[k]), 32'(msz[k] >= AF));
            chk("almost_empty", k, 32'(ae_o[k]), 32'(msz[k] <= AE));
            chk("overflow", k, 32'(ovf_o[k]), 32'(movf[k]));
            chk("underflow", k, 32'(udf_o[k]), 32'(mudf[k]));
            if (msz[k] > 0) chk("out", k, 32'(out_o[k]), 32'(mlist[k][0]));
        end
    endtask

    // Drive one cycle of stimulus, advance both models, check just after the edge.
    task automatic step(input bit rst, input bit w, input bit r, input logic [DATA_W-1:0] d, input bit clr);
        reset        = rst;
        write_trig   = w;
        read_trig    = r;
        din          = d;
        clear_status = clr;
        @(posedge clk);
        m_step(0, 1'b1, rst, w, r, d, clr);
        m_step(1, 1'b0, rst, w, r, d, clr);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        step(1'b0, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        msz[0] = 0; msz[1] = 0;
        movf[0] = 0; movf[1] = 0;
        mudf[0] = 0; mudf[1] = 0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h11 + i));
        for (int i = 0; i < DEPTH; i++) rd();

        // Write into a full FIFO without a read: policies diverge.
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h11 + i));
        wr(8'hAA);
        chk("ow_head_after_full_write", 0, 32'(out_o[0]), 32'h12);
        chk("rj_head_after_full_write", 1, 32'(out_o[1]), 32'h11);
        for (int i = 0; i < DEPTH; i++) rd();

        // Full FIFO with simultaneous read and write: no overflow.
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h11 + i));
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        chk("rw_full_head", 0, 32'(out_o[0]), 32'h12);
        for (int i = 0; i < DEPTH; i++) rd();

        // Underflow, set-wins-over-clear, then clear alone.
        rd();
        step(1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
        chk("set_wins_underflow", 1, 32'(udf_o[1]), 32'h1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        rd();

        // Pointer wrap with a steady fill of one.
        v = 8'h40;
        wr(v);
        for (int i = 0; i < 20; i++) begin
            v = v + 8'h1;
            step(1'b0, 1'b1, 1'b1, v, 1'b0);
        end
        rd();

        // Reset mid-fill, then reuse.
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        wr(8'hC5);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        wr(8'h77);
        chk("after_reset_readback", 0, 32'(out_o[0]), 32'h77);
        rd();

        // Randomised traffic including clears and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit w, r, clr, rst;
            int phase;
            phase = (i / 100) % 3;
            w   = ($urandom_range(99) < (phase == 0 ? 75 : (phase == 1 ? 25 : 50)));
            r   = ($urandom_range(99) < (phase == 0 ? 25 : (phase == 1 ? 75 : 50)));
            clr = ($urandom_range(99) < 8);
            rst = ($urandom_range(199) == 0);
            step(rst, w, r, 8'($urandom), clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
